// File: rtl/score_overlay.sv
// Gatorga score keeper: counts alien_hit edges into a 4-digit BCD score and renders it as
// seven-segment digits in its own pixel layer. Optional macro SCORE_FLASH_EN flashes the digits yellow after each score change.
module score_overlay #(
  parameter logic signed [11:0] SCORE_X    = 12'sd16,
  parameter logic signed [11:0] SCORE_Y    = 12'sd16,
  parameter int                 DIGIT_W    = 16,
  parameter int                 DIGIT_H    = 28,
  parameter int                 SEG_T      = 4,
  parameter int                 DIGIT_GAP  = 6,
  parameter logic [15:0]        POINTS_BCD = 16'h0010
) (
  input  logic                pixel_clk,
  input  logic                rst,
  input  logic                fsync,
  input  logic                alien_hit,
  input  logic signed [11:0]  hpos,
  input  logic signed [11:0]  vpos,
  output logic [7:0]          pixel [0:2],
  output logic                active,
  output logic [15:0]         score_bcd,
  output logic                saturated
);

  localparam logic signed [11:0] W_S    = 12'(DIGIT_W);
  localparam logic signed [11:0] H_S    = 12'(DIGIT_H);
  localparam logic signed [11:0] T_S    = 12'(SEG_T);
  localparam logic signed [11:0] W_T_S  = 12'(DIGIT_W - SEG_T);
  localparam logic signed [11:0] H_T_S  = 12'(DIGIT_H - SEG_T);
  localparam logic signed [11:0] HALF_S = 12'(DIGIT_H / 2);
  localparam logic signed [11:0] G_LO_S = 12'((DIGIT_H - SEG_T) / 2);
  localparam logic signed [11:0] G_HI_S = 12'((DIGIT_H + SEG_T) / 2);
  localparam int                 PITCH  = DIGIT_W + DIGIT_GAP;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT} state_e;

  state_e        state_q;
  logic [1:0]    dig_q;
  logic [15:0]   work_q;
  logic [15:0]   score_q;
  logic [15:0]   disp_q;
  logic          carry_q;
  logic          sat_q;
  logic          hit_prev_q;
  logic [3:0]    pending_q;
  logic [3:0]    pending_d;

  logic          hit_evt;
  logic          deq;
  logic          enq;
  logic [3:0]    work_dig;
  logic [3:0]    pts_dig;
  logic [4:0]    sum;
  logic [3:0]    sum_dig;
  logic          sum_carry;
  logic          lit;
  logic          yellow;

  assign score_bcd = score_q;
  assign saturated = sat_q;

  assign hit_evt = alien_hit && !hit_prev_q;
  assign deq     = (state_q == S_IDLE) && (pending_q != 4'd0) && !sat_q;
  // A simultaneous dequeue frees a slot, so a full queue still accepts that event.
  assign enq     = hit_evt && ((pending_q != 4'd15) || deq);

  always_comb begin
    pending_d = pending_q;
    if ((state_q == S_IDLE) && sat_q) begin
      pending_d = 4'd0;
    end else if (enq && !deq) begin
      pending_d = pending_q + 4'd1;
    end else if (deq && !enq) begin
      pending_d = pending_q - 4'd1;
    end
  end

  always_comb begin
    work_dig = work_q[{dig_q, 2'b00} +: 4];
    pts_dig  = POINTS_BCD[{dig_q, 2'b00} +: 4];
    sum      = {1'b0, work_dig} + {1'b0, pts_dig} + {4'd0, carry_q};
    if (sum > 5'd9) begin
      sum_dig   = 4'(sum - 5'd10);
      sum_carry = 1'b1;
    end else begin
      sum_dig   = sum[3:0];
      sum_carry = 1'b0;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dig_q      <= 2'd0;
      work_q     <= 16'h0000;
      score_q    <= 16'h0000;
      disp_q     <= 16'h0000;
      carry_q    <= 1'b0;
      sat_q      <= 1'b0;
      hit_prev_q <= 1'b0;
      pending_q  <= 4'd0;
    end else begin
      hit_prev_q <= alien_hit;
      pending_q  <= pending_d;
      if (fsync) begin
        disp_q <= score_q;
      end
      case (state_q)
        S_IDLE: begin
          if (deq) begin
            state_q <= S_ADD;
            dig_q   <= 2'd0;
            work_q  <= score_q;
            carry_q <= 1'b0;
          end
        end
        S_ADD: begin
          work_q[{dig_q, 2'b00} +: 4] <= sum_dig;
          carry_q <= sum_carry;
          dig_q   <= dig_q + 2'd1;
          if (dig_q == 2'd3) begin
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          // A carry out of the top digit means the true score passed 9999.
          if (carry_q) begin
            score_q <= 16'h9999;
            sat_q   <= 1'b1;
          end else begin
            score_q <= work_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SCORE_FLASH_EN
  logic [5:0] flash_q;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      flash_q <= 6'd0;
    end else if (state_q == S_COMMIT) begin
      flash_q <= 6'd32;
    end else if (fsync && (flash_q != 6'd0)) begin
      flash_q <= flash_q - 6'd1;
    end
  end

  assign yellow = (flash_q != 6'd0) && flash_q[2];
`else
  assign yellow = 1'b0;
`endif

  function automatic logic digit_lit(input logic [3:0]         v,
                                     input logic signed [11:0] lx,
                                     input logic signed [11:0] ly);
    logic [6:0] seg;
    logic [6:0] pat;
    logic       upper;
    upper  = ly < HALF_S;
    // Bit order a,b,c,d,e,f,g from MSB to LSB.
    seg[6] = ly < T_S;
    seg[5] = (lx >= W_T_S) && upper;
    seg[4] = (lx >= W_T_S) && !upper;
    seg[3] = ly >= H_T_S;
    seg[2] = (lx < T_S) && !upper;
    seg[1] = (lx < T_S) && upper;
    seg[0] = (ly >= G_LO_S) && (ly < G_HI_S);
    case (v)
      4'd0:    pat = 7'b1111110;
      4'd1:    pat = 7'b0110000;
      4'd2:    pat = 7'b1101101;
      4'd3:    pat = 7'b1111001;
      4'd4:    pat = 7'b0110011;
      4'd5:    pat = 7'b1011011;
      4'd6:    pat = 7'b1011111;
      4'd7:    pat = 7'b1110000;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1111011;
      default: pat = 7'b0000000;
    endcase
    return (lx >= 0) && (lx < W_S) && (ly >= 0) && (ly < H_S) && (|(seg & pat));
  endfunction

  always_comb begin
    lit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lit = lit | digit_lit(disp_q[4*k +: 4],
                            hpos - (SCORE_X + 12'((3 - k) * PITCH)),
                            vpos - SCORE_Y);
    end
  end

  always_comb begin
    active   = lit;
    pixel[0] = (lit && !yellow) ? 8'hFF : 8'h00;
    pixel[1] = lit ? 8'hFF : 8'h00;
    pixel[2] = lit ? 8'hFF : 8'h00;
  end

endmodule

// File: tb/tb_score_overlay.sv
// Bench for score_overlay: random hits, frame syncs and pixel probes checked against a
// decimal-score model with a cycle budget per queued hit and a rectangle-based digit renderer.
module tb_score_overlay;

  logic               pixel_clk = 1'b0;
  logic               rst = 1'b0;
  logic               fsync = 1'b0;
  logic               alien_hit = 1'b0;
  logic signed [11:0] hpos = '0;
  logic signed [11:0] vpos = '0;
  logic [7:0]         pixel [0:2];
  logic               active;
  logic [15:0]        score_bcd;
  logic               saturated;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state (decimal score, queued hits, cycles left in current add)
  int m_score, m_disp, m_pend, m_busy;
  bit m_sat, m_prev;

  score_overlay dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .fsync     (fsync),
    .alien_hit (alien_hit),
    .hpos      (hpos),
    .vpos      (vpos),
    .pixel     (pixel),
    .active    (active),
    .score_bcd (score_bcd),
    .saturated (saturated)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [15:0] to_bcd(input int s);
    return 16'(((s / 1000) % 10) << 12 | ((s / 100) % 10) << 8 | ((s / 10) % 10) << 4 | (s % 10));
  endfunction

  // Digit k occupies x in [16+(3-k)*22, +16), y in [16, 44); segments as rectangles.
  function automatic bit exp_lit(input int h, input int v, input int disp);
    int digs [4];
    bit [6:0] pats [10];
    bit [6:0] on;
    int lx, ly;
    bit r;
    pats = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    digs[0] = disp % 10; digs[1] = (disp / 10) % 10;
    digs[2] = (disp / 100) % 10; digs[3] = (disp / 1000) % 10;
    r = 0;
    for (int k = 0; k < 4; k++) begin
      lx = h - (16 + (3 - k) * 22);
      ly = v - 16;
      if (lx >= 0 && lx < 16 && ly >= 0 && ly < 28) begin
        on[6] = (ly < 4);
        on[5] = (lx >= 12 && ly < 14);
        on[4] = (lx >= 12 && ly >= 14);
        on[3] = (ly >= 24);
        on[2] = (lx < 4 && ly >= 14);
        on[1] = (lx < 4 && ly < 14);
        on[0] = (ly >= 12 && ly < 16);
        if ((on & pats[digs[k]]) != 0) r = 1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_score = 0; m_disp = 0; m_pend = 0; m_busy = 0; m_sat = 0; m_prev = 0;
  endtask

  // Advance the model by one clock edge using the current inputs, then let the DUT take it.
  task automatic tick();
    bit ev, deq, acc;
    ev = alien_hit && !m_prev;
    m_prev = alien_hit;
    if (fsync) m_disp = m_score;
    if (m_busy == 0) begin
      deq = (m_pend > 0) && !m_sat;
      if (m_sat) begin
        m_pend = 0;
      end else begin
        acc = ev && (m_pend < 15 || deq);
        m_pend = m_pend + int'(acc) - int'(deq);
        if (deq) m_busy = 5;
      end
    end else begin
      acc = ev && (m_pend < 15);
      m_pend = m_pend + int'(acc);
      m_busy--;
      if (m_busy == 0) begin
        m_score += 10;
        if (m_score > 9999) begin m_score = 9999; m_sat = 1; end
      end
    end
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic do_reset();
    alien_hit = 0; fsync = 0;
    rst = 1;
    @(posedge pixel_clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_score actual=%h required=0000", score_bcd); end
    n_cmp++;
    if (saturated !== 1'b0) begin n_fail++; $display("FAIL reset_sat actual=%b required=0", saturated); end
    fsync = 1; tick(); fsync = 0;
    hpos = 16; vpos = 16; #1;
    n_cmp++;
    if (active !== 1'b1) begin n_fail++; $display("FAIL reset_corner_active actual=%b required=1", active); end
    n_cmp++;
    if ({pixel[2], pixel[1], pixel[0]} !== 24'hFFFFFF) begin
      n_fail++; $display("FAIL reset_corner_pixel actual=%h required=ffffff", {pixel[2], pixel[1], pixel[0]});
    end
    hpos = 21; vpos = 21; #1;
    n_cmp++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL reset_hollow_active actual=%b required=0", active); end
    n_cmp++;
    if ({pixel[2], pixel[1], pixel[0]} !== 24'h000000) begin
      n_fail++; $display("FAIL reset_hollow_pixel actual=%h required=000000", {pixel[2], pixel[1], pixel[0]});
    end
  endtask

  task automatic test_hold_hit();
    for (int t = 1; t <= 14; t++) begin
      alien_hit = (t <= 3);
      tick();
      n_cmp++;
      if (score_bcd !== ((t >= 7) ? 16'h0010 : 16'h0000)) begin
        n_fail++; $display("FAIL hold_hit_t%0d actual=%h required=%h", t, score_bcd, (t >= 7) ? 16'h0010 : 16'h0000);
      end
    end
    alien_hit = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int t = 0; t < 50; t++) begin
      alien_hit = (t < 10) && (t % 2 == 0);
      tick();
      n_cmp++;
      if (score_bcd !== to_bcd(m_score)) begin
        n_fail++; $display("FAIL b2b_t%0d actual=%h required=%h", t, score_bcd, to_bcd(m_score));
      end
    end
    n_cmp++;
    if (score_bcd !== 16'h0050) begin n_fail++; $display("FAIL b2b_final actual=%h required=0050", score_bcd); end
  endtask

  task automatic test_midframe();
    do_reset();
    fsync = 1; tick(); fsync = 0;
    alien_hit = 1; tick(); alien_hit = 0;
    for (int t = 0; t < 8; t++) tick();
    n_cmp++;
    if (score_bcd !== 16'h0010) begin n_fail++; $display("FAIL mid_score actual=%h required=0010", score_bcd); end
    hpos = 66; vpos = 17; #1;
    n_cmp++;
    if (active !== 1'b1) begin n_fail++; $display("FAIL mid_before_fsync actual=%b required=1", active); end
    fsync = 1; tick(); fsync = 0;
    n_cmp++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL mid_after_fsync_a actual=%b required=0", active); end
    hpos = 74; vpos = 20; #1;
    n_cmp++;
    if (active !== 1'b1) begin n_fail++; $display("FAIL mid_after_fsync_b actual=%b required=1", active); end
  endtask

  task automatic test_random();
    logic [23:0] exp_px;
    bit          el;
    do_reset();
    for (int t = 0; t < 600; t++) begin
      alien_hit = ($urandom_range(0, 3) == 0);
      fsync = ($urandom_range(0, 15) == 0);
      hpos = 12'($urandom_range(0, 110)) - 12'sd4;
      vpos = 12'($urandom_range(0, 50));
      tick();
      el = exp_lit(int'(hpos), int'(vpos), m_disp);
      exp_px = el ? 24'hFFFFFF : 24'h000000;
      n_cmp++;
      if (score_bcd !== to_bcd(m_score)) begin
        n_fail++; $display("FAIL rand_score_t%0d actual=%h required=%h", t, score_bcd, to_bcd(m_score));
      end
      n_cmp++;
      if (active !== el || {pixel[2], pixel[1], pixel[0]} !== exp_px) begin
        n_fail++; $display("FAIL rand_pixel_t%0d (%0d,%0d) actual=%b/%h required=%b/%h",
                           t, hpos, vpos, active, {pixel[2], pixel[1], pixel[0]}, el, exp_px);
      end
    end
    alien_hit = 0; fsync = 0;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      alien_hit = 1; tick(); alien_hit = 0;
      for (int t = 0; t < 6; t++) tick();
      if (score_bcd !== to_bcd(m_score) || saturated !== m_sat) begin
        n_cmp++; n_fail++;
        $display("FAIL sat_hit%0d actual=%h/%b required=%h/%b", i, score_bcd, saturated, to_bcd(m_score), m_sat);
      end
    end
    n_cmp++;
    if (score_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_score actual=%h required=9999", score_bcd); end
    n_cmp++;
    if (saturated !== 1'b1) begin n_fail++; $display("FAIL sat_flag actual=%b required=1", saturated); end
    alien_hit = 1; tick(); alien_hit = 0;
    for (int t = 0; t < 10; t++) tick();
    n_cmp++;
    if (score_bcd !== 16'h9999 || saturated !== 1'b1) begin
      n_fail++; $display("FAIL sat_extra_hit actual=%h/%b required=9999/1", score_bcd, saturated);
    end
    fsync = 1; tick(); fsync = 0;
    hpos = 99; vpos = 29; #1;
    n_cmp++;
    if (active !== exp_lit(99, 29, 9999)) begin
      n_fail++; $display("FAIL sat_render actual=%b required=%b", active, exp_lit(99, 29, 9999));
    end
  endtask

  task automatic test_reset_mid_add();
    do_reset();
    alien_hit = 1; tick(); alien_hit = 0;
    for (int t = 0; t < 8; t++) tick();
    alien_hit = 1; tick(); alien_hit = 0;
    tick(); tick(); tick();
    rst = 1;
    #2;
    n_cmp++;
    if (score_bcd !== 16'h0000 || saturated !== 1'b0) begin
      n_fail++; $display("FAIL midadd_reset actual=%h/%b required=0000/0", score_bcd, saturated);
    end
    rst = 0;
    model_reset();
    for (int t = 0; t < 12; t++) tick();
    n_cmp++;
    if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL midadd_idle actual=%h required=0000", score_bcd); end
    for (int t = 1; t <= 8; t++) begin
      alien_hit = (t == 1);
      tick();
      n_cmp++;
      if (score_bcd !== ((t >= 7) ? 16'h0010 : 16'h0000)) begin
        n_fail++; $display("FAIL midadd_rehit_t%0d actual=%h required=%h", t, score_bcd, (t >= 7) ? 16'h0010 : 16'h0000);
      end
    end
    alien_hit = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hold_hit();
    test_back_to_back();
    test_midframe();
    test_random();
    test_saturate();
    test_reset_mid_add();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
